reg_sweeper: RTL and testbench
==============================

REG_SWEEPER -- requirements
Module: reg_sweeper

Interface
REQ-001 Parameter REG_W, default 5: width of regnum.
REQ-002 Parameter BASE, default 8: register number emitted while armed, and sweep origin.
REQ-003 Parameter STEPS, default 4: number of run steps per sweep.
REQ-004 Parameter STRIDE, default 1: register-number increment per step.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 go  in  1  arm/start request, level-sensitive.
REQ-008 mode  in  2  sweep pattern: 0 up, 1 down, 2 outward, 3 treated as up.
REQ-009 stall  in  1  freezes the sweep while high in RUN.
REQ-010 abort  in  1  cancels a sweep in RUN.
REQ-011 regnum  out  REG_W  current target register number.
REQ-012 wr_en  out  1  regnum is valid for a write this cycle.
REQ-013 busy  out  1  high in ARMED or RUN.
REQ-014 done  out  1  high only in DONE.

Function
REQ-015 States SHALL be IDLE, ARMED, RUN and DONE, with an internal step counter k in 1..STEPS sized $clog2(STEPS+1).
REQ-016 Transitions from IDLE SHALL be: go to ARMED, otherwise stay in IDLE.
REQ-017 Transitions from ARMED SHALL be:
- go high: stay in ARMED.
- go low: latch mode and enter RUN with k=1.
- go low with STEPS==0: enter DONE.
REQ-018 Transitions from RUN SHALL be evaluated in this priority order:
- abort: go to IDLE.
- stall: hold state and k.
- k==STEPS: go to DONE.
- otherwise: k+1.
REQ-019 Transitions from DONE SHALL be: go to ARMED, otherwise stay in DONE.
REQ-020 go in RUN and abort or stall outside RUN SHALL be ignored.
REQ-021 regnum SHALL be 0 in IDLE and DONE, and BASE in ARMED.
REQ-022 regnum in RUN SHALL follow the latched mode:
- up: BASE + k*STRIDE.
- down: BASE - k*STRIDE.
- outward: BASE + ceil(k/2)*STRIDE for odd k, BASE - (k/2)*STRIDE for even k.
REQ-023 All regnum arithmetic SHALL be modulo 2^REG_W; wrap-around is legal, including to 0.
REQ-024 wr_en SHALL equal ARMED | (RUN & ~stall); regnum SHALL hold its value while stalled.
REQ-025 Absent stall, a sweep SHALL occupy exactly STEPS cycles in RUN, with done asserted on the cycle after the last step.
REQ-026 A mode change during RUN SHALL NOT affect the current sweep.
REQ-027 abort and stall asserted together SHALL resolve to abort.

Reset
REQ-028 reset SHALL force IDLE and k=0 on the next edge, from any state including mid-RUN, overriding go and abort.
REQ-029 After reset, outputs SHALL be regnum=0, wr_en=0, busy=0, done=0.

Structure
REQ-030 Package reg_sweeper_pkg SHALL hold the state enum and the mode constants (MODE_UP, MODE_DOWN, MODE_OUT).
REQ-031 Sub-module reg_sweep_addr SHALL be a combinational generator: (base, stride, k, mode) to regnum.
REQ-032 The FSM and the counter SHALL reside in reg_sweeper.

Verification (default parameters unless stated)
REQ-033 Up sweep: reset; go=1 for 2 cycles; go=0 with mode=0 -> regnum 8,8,9,10,11,12 with wr_en=1, then done=1, regnum=0.
REQ-034 Down and outward sweeps:
- mode=1 -> RUN regnum 7,6,5,4, then done.
- mode=2 -> RUN regnum 9,7,10,6, then done.
REQ-035 Wrap: BASE=30, mode=0 -> RUN regnum 31,0,1,2 with wr_en=1 throughout, including at regnum 0.
REQ-036 Stall and restart: stall=1 for 3 cycles at k=2 with mode=0 -> regnum holds 10 with wr_en=0, then 11,12, then done; go=1 from DONE -> ARMED with regnum=8.
REQ-037 abort at k=3 -> next cycle IDLE, regnum=0, done=0, busy=0; abort together with stall gives the same result.
REQ-038 reset mid-RUN at k=2 -> next cycle IDLE with all outputs 0; go in IDLE re-arms.

Source files
------------

// File: rtl/reg_sweeper_pkg.sv
// Shared types and constants for the register sweeper: FSM state encoding
// and the sweep-pattern codes carried on the mode input.
package reg_sweeper_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Sweep patterns; code 3 is not listed and falls back to an upward sweep.
   localparam logic [1:0] MODE_UP   = 2'd0;
   localparam logic [1:0] MODE_DOWN = 2'd1;
   localparam logic [1:0] MODE_OUT  = 2'd2;

endpackage

// File: rtl/reg_sweep_addr.sv
// Combinational register-number generator: maps (base, stride, step k, mode)
// to the target register. All arithmetic is modulo 2^REG_W, so wrap-around
// (including landing on register 0) is simply the natural truncation.
module reg_sweep_addr
   import reg_sweeper_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int KW    = 3
) (
   input  logic [REG_W-1:0] base,
   input  logic [REG_W-1:0] stride,
   input  logic [KW-1:0]    k,
   input  logic [1:0]       mode,
   output logic [REG_W-1:0] regnum
);

   logic [KW:0]      half_k;
   logic [REG_W-1:0] k_r;
   logic [REG_W-1:0] half_r;
   logic [REG_W-1:0] step_off;
   logic [REG_W-1:0] half_off;

   // Offsets are formed in REG_W bits directly: truncating k first gives the
   // same result modulo 2^REG_W. half_k is ceil(k/2) for odd k, k/2 for even.
   always_comb begin
      half_k   = ({1'b0, k} + {{KW{1'b0}}, k[0]}) >> 1;
      k_r      = REG_W'(k);
      half_r   = REG_W'(half_k);
      step_off = k_r * stride;
      half_off = half_r * stride;
      case (mode)
         MODE_DOWN: regnum = base - step_off;
         MODE_OUT:  regnum = k[0] ? (base + half_off) : (base - half_off);
         default:   regnum = base + step_off;
      endcase
   end

endmodule

// File: rtl/reg_sweeper.sv
// Register sweeper: once armed by go, waits for go to drop, latches the
// sweep pattern and steps through STEPS register numbers around BASE,
// offering each for a write. stall freezes a sweep, abort cancels it.
//
// Handshake: there is no backpressure from the consumer. wr_en high means
// regnum is a valid write target in that same cycle; the consumer must take
// it then. A stalled RUN cycle drops wr_en and holds regnum unchanged.
module reg_sweeper
   import reg_sweeper_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int BASE   = 8,
   parameter int STEPS  = 4,
   parameter int STRIDE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic [1:0]       mode,
   input  logic             stall,
   input  logic             abort,
   output logic [REG_W-1:0] regnum,
   output logic             wr_en,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   // Step counter width; kept at least one bit wide so STEPS==0 still builds.
   localparam int KW = (STEPS < 1) ? 1 : $clog2(STEPS + 1);
   localparam logic [KW-1:0]    STEPS_K  = KW'(STEPS);
   localparam logic [REG_W-1:0] BASE_R   = REG_W'(BASE);
   localparam logic [REG_W-1:0] STRIDE_R = REG_W'(STRIDE);

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [1:0]      mode_q, mode_d;
   logic [REG_W-1:0] run_regnum;

   reg_sweep_addr #(
      .REG_W (REG_W),
      .KW    (KW)
   ) u_addr (
      .base   (BASE_R),
      .stride (STRIDE_R),
      .k      (k_q),
      .mode   (mode_q),
      .regnum (run_regnum)
   );

   // State, step counter and latched pattern; reset wins over every input.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         mode_q  <= MODE_UP;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic; in RUN, abort outranks stall, which outranks stepping.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_ARMED;
               k_d     = '0;
            end
         end
         S_ARMED: begin
            if (!go) begin
               mode_d = mode;
               if (STEPS == 0) begin
                  state_d = S_DONE;
                  k_d     = '0;
               end else begin
                  state_d = S_RUN;
                  k_d     = KW'(1);
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               k_d     = '0;
            end else if (stall) begin
               state_d = S_RUN;
            end else if (k_q == STEPS_K) begin
               state_d = S_DONE;
               k_d     = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DONE: begin
            if (go) begin
               state_d = S_ARMED;
            end
         end
         default: begin
            state_d = S_IDLE;
            k_d     = '0;
         end
      endcase
   end

   // Outputs decoded from the registered state; only wr_en sees stall directly.
   always_comb begin
      regnum    = '0;
      wr_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      state_dbg = state_q;
      case (state_q)
         S_ARMED: begin
            regnum = BASE_R;
            wr_en  = 1'b1;
            busy   = 1'b1;
         end
         S_RUN: begin
            regnum = run_regnum;
            wr_en  = ~stall;
            busy   = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            regnum = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_sweeper.sv
// Bench for reg_sweeper: two instances (BASE=8 and BASE=30) share stimulus.
// A queue-based sweep model predicts every cycle; directed literal checks
// pin the model to hand-worked sequences before a randomized run.
module tb_reg_sweeper;

   localparam int REG_W  = 5;
   localparam int BASE_A = 8;
   localparam int BASE_B = 30;
   localparam int STEPS  = 4;
   localparam int STRIDE = 1;
   localparam int MOD    = 1 << REG_W;
   localparam int W      = 2 * REG_W + 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1;
   logic             go = 1'b0, stall = 1'b0, abort = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [REG_W-1:0] regnum_a, regnum_b;
   logic             wr_en_a, busy_a, done_a, wr_en_b, busy_b, done_b;
   logic [1:0]       state_a, state_b;

   reg_sweeper #(.REG_W(REG_W), .BASE(BASE_A), .STEPS(STEPS), .STRIDE(STRIDE)) dut_a (
      .clock(clk), .reset(rst), .go(go), .mode(mode), .stall(stall), .abort(abort),
      .regnum(regnum_a), .wr_en(wr_en_a), .busy(busy_a), .done(done_a), .state_dbg(state_a));

   reg_sweeper #(.REG_W(REG_W), .BASE(BASE_B), .STEPS(STEPS), .STRIDE(STRIDE)) dut_b (
      .clock(clk), .reset(rst), .go(go), .mode(mode), .stall(stall), .abort(abort),
      .regnum(regnum_b), .wr_en(wr_en_b), .busy(busy_b), .done(done_b), .state_dbg(state_b));

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 armed, 2 sweeping, 3 finished. A sweep is a queue of
   // the register numbers still to be offered; its head is the current one.
   int ph = 0;
   int qa[$];
   int qb[$];

   function automatic int sweep_reg(input int b, input logic [1:0] m, input int k);
      int off;
      case (m)
         2'd1:    off = -k * STRIDE;
         2'd2:    off = (k % 2 == 1) ? ((k + 1) / 2) * STRIDE : -(k / 2) * STRIDE;
         default: off = k * STRIDE;
      endcase
      return (((b + off) % MOD) + MOD) % MOD;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ph = 0;
         qa.delete();
         qb.delete();
      end else begin
         case (ph)
            0: if (go) ph = 1;
            1: if (!go) begin
                  for (int k = 1; k <= STEPS; k++) begin
                     qa.push_back(sweep_reg(BASE_A, mode, k));
                     qb.push_back(sweep_reg(BASE_B, mode, k));
                  end
                  ph = (STEPS == 0) ? 3 : 2;
               end
            2: if (abort) begin
                  ph = 0;
                  qa.delete();
                  qb.delete();
               end else if (!stall) begin
                  void'(qa.pop_front());
                  void'(qb.pop_front());
                  if (qa.size() == 0) ph = 3;
               end
            default: if (go) ph = 1;
         endcase
      end
   end

   // ---------------- scoreboard / compare ----------------
   logic [W-1:0] exp_q[$];

   always @(negedge clk) begin
      logic [REG_W-1:0] er_a, er_b;
      logic ew, eb, ed;
      logic [W-1:0] ev, av;
      er_a = '0; er_b = '0; ew = 1'b0; eb = 1'b0; ed = 1'b0;
      case (ph)
         0: ;
         1: begin er_a = REG_W'(BASE_A); er_b = REG_W'(BASE_B); ew = 1'b1; eb = 1'b1; end
         2: begin er_a = REG_W'(qa[0]); er_b = REG_W'(qb[0]); ew = ~stall; eb = 1'b1; end
         default: ed = 1'b1;
      endcase
      exp_q.push_back({er_a, ew, eb, ed, er_b, ew, eb, ed});
      ev = exp_q.pop_front();
      av = {regnum_a, wr_en_a, busy_a, done_a, regnum_b, wr_en_b, busy_b, done_b};
      if (chk_en) begin
         n_vec++;
         if (av !== ev) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t got a:reg=%0d wr=%0b busy=%0b done=%0b b:reg=%0d wr=%0b busy=%0b done=%0b, want a:reg=%0d wr=%0b busy=%0b done=%0b b:reg=%0d wr=%0b busy=%0b done=%0b",
                     $time, regnum_a, wr_en_a, busy_a, done_a, regnum_b, wr_en_b, busy_b, done_b,
                     er_a, ew, eb, ed, er_b, ew, eb, ed);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic d(input logic g, input logic [1:0] m, input logic s, input logic a, input logic r);
      @(posedge clk);
      #1;
      go = g; mode = m; stall = s; abort = a; rst = r;
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input int r, input int w, input int b, input int dn);
      logic [REG_W-1:0] rr;
      rr = REG_W'(r);
      n_vec++;
      if (regnum_a !== rr || wr_en_a !== w[0] || busy_a !== b[0] || done_a !== dn[0]) begin
         n_bad++;
         $display("FAIL %s got reg=%0d wr=%0b busy=%0b done=%0b want reg=%0d wr=%0d busy=%0d done=%0d",
                  nm, regnum_a, wr_en_a, busy_a, done_a, r, w, b, dn);
      end
   endtask

   task automatic litb(input string nm, input int r, input int w);
      logic [REG_W-1:0] rr;
      rr = REG_W'(r);
      n_vec++;
      if (regnum_b !== rr || wr_en_b !== w[0]) begin
         n_bad++;
         $display("FAIL %s got reg=%0d wr=%0b want reg=%0d wr=%0d", nm, regnum_b, wr_en_b, r, w);
      end
   endtask

   // From IDLE or DONE: arm for one cycle, sweep with random mode noise, finish.
   task automatic sweep(input logic [1:0] m, input int e[4], input string nm);
      d(1, m, 0, 0, 0);
      d(0, m, 0, 0, 0);
      lit({nm, "_arm"}, BASE_A, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         d(0, 2'($urandom_range(0, 3)), 0, 0, 0);
         lit(nm, e[i], 1, 1, 0);
      end
      d(0, 0, 0, 0, 0);
      lit({nm, "_done"}, 0, 0, 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      d(0, 0, 0, 0, 1);
      chk_en = 1'b1;

      // Up sweep with go held two cycles; BASE=30 instance shows wrap-around.
      d(1, 0, 0, 0, 0); lit("reset_idle", 0, 0, 0, 0);
      d(1, 0, 0, 0, 0); lit("up_arm1", 8, 1, 1, 0);
      d(0, 0, 0, 0, 0); lit("up_arm2", 8, 1, 1, 0);
      d(0, 3, 0, 0, 0); lit("up_k1", 9, 1, 1, 0);  litb("wrap_k1", 31, 1);
      d(0, 1, 0, 0, 0); lit("up_k2", 10, 1, 1, 0); litb("wrap_k2", 0, 1);
      d(0, 2, 0, 0, 0); lit("up_k3", 11, 1, 1, 0); litb("wrap_k3", 1, 1);
      d(0, 0, 0, 0, 0); lit("up_k4", 12, 1, 1, 0); litb("wrap_k4", 2, 1);
      d(0, 0, 0, 0, 0); lit("up_done", 0, 0, 0, 1);

      sweep(2'd1, '{7, 6, 5, 4}, "down");
      sweep(2'd2, '{9, 7, 10, 6}, "outward");

      // Stall three cycles at k=2, then resume and restart from DONE.
      d(1, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0); lit("st_arm", 8, 1, 1, 0);
      d(0, 0, 0, 0, 0); lit("st_k1", 9, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         d(0, 0, 1, 0, 0); lit("st_hold", 10, 0, 1, 0);
      end
      d(0, 0, 0, 0, 0); lit("st_k2", 10, 1, 1, 0);
      d(0, 0, 0, 0, 0); lit("st_k3", 11, 1, 1, 0);
      d(0, 0, 0, 0, 0); lit("st_k4", 12, 1, 1, 0);
      d(1, 0, 0, 0, 0); lit("st_done", 0, 0, 0, 1);
      d(1, 0, 0, 0, 0); lit("restart_arm", 8, 1, 1, 0);

      // Abort at k=3.
      d(0, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0); lit("ab_k1", 9, 1, 1, 0);
      d(0, 0, 0, 0, 0);
      d(0, 0, 0, 1, 0); lit("ab_k3", 11, 1, 1, 0);
      d(0, 0, 0, 0, 0); lit("ab_idle", 0, 0, 0, 0);

      // Abort together with stall at k=3.
      d(1, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0);
      d(0, 0, 1, 1, 0); lit("abst_k3", 11, 0, 1, 0);
      d(0, 0, 0, 0, 0); lit("abst_idle", 0, 0, 0, 0);

      // Reset mid-sweep at k=2 overrides go and abort; go then re-arms.
      d(1, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0);
      d(0, 0, 0, 0, 0);
      d(1, 0, 0, 1, 1); lit("rst_k2", 10, 1, 1, 0);
      d(1, 0, 0, 0, 0); lit("rst_idle", 0, 0, 0, 0);
      d(0, 0, 0, 0, 0); lit("rst_rearm", 8, 1, 1, 0);

      // Randomized traffic checked every cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         d($urandom_range(0, 99) < 30,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 199) == 0);
      end

      d(0, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
